adder_arbiter: RTL and testbench
================================

# adder_arbiter

- Round-robin arbiter and sequencer that shares one BITS_WIDTH-bit adder datapath among NUM_REQ requesters.
- Each request carries operands a, b and a carry-in. The block accepts one request per transaction, computes a + b + cin into a BITS_WIDTH+1 result (carry in the MSB) and returns it on a single response port, tagged with the requester index.
- It sits between the lab's operand sources (switch/button front-ends, test sequencers) and the display/result logic.
- Operand and result widths follow the pkg_bits types: bits_t for operands, bitsw_t for results.

## Interface

Parameters:
- BITS_WIDTH, default pkg_bits::BITS_WIDTH (4): operand width.
- NUM_REQ, default 4: number of requesters, range 2..8.
- ID_W, derived as $clog2(NUM_REQ): requester index width. Not overridable.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1: rising-edge clock.
  - rst_n, input, 1: asynchronous active-low reset.
- Request side:
  - req_valid_i, input, NUM_REQ: per-requester request valid.
  - req_a_i, input, NUM_REQ*BITS_WIDTH: operand a. Requester k occupies bits [k*BITS_WIDTH +: BITS_WIDTH].
  - req_b_i, input, NUM_REQ*BITS_WIDTH: operand b, same packing as req_a_i.
  - req_cin_i, input, NUM_REQ: per-requester carry-in.
  - req_ready_o, output, NUM_REQ: one-hot accept. Never more than one bit high.
- Response side:
  - rsp_valid_o, output, 1: result available.
  - rsp_id_o, output, ID_W: index of the requester that owns the result.
  - rsp_sum_o, output, BITS_WIDTH+1: sum; the MSB is the carry-out.
  - rsp_ready_i, input, 1: consumer accepts the response.
- Status:
  - busy_o, output, 1: high whenever the state is not IDLE.

## Operation

The FSM has three states: IDLE, EXEC and RESP.

IDLE:
- req_ready_o is combinational. It is one-hot on the selected requester, all zero if no req_valid_i bit is set.
- Selection: the first valid requester scanning upward from (ptr+1) mod NUM_REQ, wrapping.
- On a clock edge with a selected requester, the block:
  - latches a, b, cin and the index;
  - goes to EXEC.

EXEC:
- Registers sum = a + b + cin, zero-extended to BITS_WIDTH+1 bits; no overflow is possible.
- Goes to RESP.
- req_ready_o = 0.

RESP:
- rsp_valid_o = 1.
- rsp_id_o and rsp_sum_o are held stable until rsp_ready_i = 1 at a clock edge.
- On that edge the block:
  - updates ptr to the served index;
  - returns to IDLE.
- req_ready_o = 0 throughout.

Round-robin and fairness:
- ptr resets to NUM_REQ-1, so requester 0 has the highest priority after reset.
- With all requesters continuously valid, the service order is 0,1,…,NUM_REQ-1,0,…

Handshake rules:
- A request transfers only when req_valid_i[k] & req_ready_o[k] are both high at a clock edge.
- Requesters are expected to hold valid and operands until accepted. The block tolerates valid being dropped before acceptance; no transfer occurs and nothing is latched.
- Operands are sampled only at the accept edge. Changes afterwards do not affect the in-flight result.
- rsp_ready_i is ignored outside RESP.

Reset values (asynchronous on rst_n low):
- state = IDLE, ptr = NUM_REQ-1.
- rsp_valid_o = 0, rsp_id_o = 0, rsp_sum_o = 0, busy_o = 0.
- req_ready_o is all zero during reset.

Reset mid-operation:
- An in-flight request in EXEC or RESP is discarded; no response is produced.
- The requester must re-request after reset.

## Timing

- Latency: accept at edge N, rsp_valid_o high after edge N+1 (visible in cycle N+2 relative to the accept cycle).
- Back-to-back service with rsp_ready_i tied high:
  - one transaction every 3 cycles;
  - req_ready_o high in cycle 0;
  - EXEC in cycle 1;
  - RESP in cycle 2;
  - next accept in cycle 3.
- Response stall: with rsp_ready_i low, the block stays in RESP indefinitely. No new accept happens and all outputs are frozen.
- busy_o is registered-state decoded: high from the cycle after accept until the cycle after the response handshake.
- No combinational path from rsp_ready_i to any output.
- req_ready_o depends combinationally on req_valid_i, ptr and state only.

## Test plan

- Reset and single request:
  - Stimulus: rst_n low then high; requester 2 presents a=4'h7, b=4'h8, cin=1.
  - Required: req_ready_o=4'b0100 in the first cycle; rsp_valid_o two cycles later with rsp_id_o=2, rsp_sum_o=5'h10; busy_o high through RESP.
- Maximum sum:
  - Stimulus: requester 0 presents a=4'hF, b=4'hF, cin=1.
  - Required: rsp_sum_o=5'h1F. The same operands with cin=0 give 5'h1E.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, rsp_ready_i=1.
  - Required: grant order 0,1,2,3,0,1; each response 3 cycles apart; rsp_id_o matches each requester's operands.
- Response backpressure:
  - Stimulus: rsp_ready_i held low for 5 cycles in RESP while requesters 1 and 3 are valid.
  - Required: rsp_valid_o, rsp_id_o and rsp_sum_o stable for all 5 cycles; req_ready_o=0; after rsp_ready_i=1, the next grant goes to the requester after the served index.
- Operand isolation:
  - Stimulus: change req_a_i of the accepted requester during EXEC and RESP.
  - Required: rsp_sum_o reflects only the operands latched at the accept edge.
- Asynchronous reset in RESP:
  - Stimulus: pull rst_n low mid-cycle while rsp_valid_o=1.
  - Required: rsp_valid_o=0 and busy_o=0 immediately, without waiting for a clock edge; after release, requester 0 wins if several requesters are valid.

Source files
------------

// File: rtl/pkg_bits.sv
// rtl/pkg_bits.sv - shared operand/result widths and types for the adder datapath
//
// BITS_WIDTH : operand width
// bits_t     : operand type, BITS_WIDTH bits
// bitsw_t    : result type, BITS_WIDTH+1 bits (carry-out in the MSB)
package pkg_bits;

    localparam int BITS_WIDTH = 4;

    typedef logic [BITS_WIDTH-1:0] bits_t;
    typedef logic [BITS_WIDTH:0]   bitsw_t;

endpackage

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder among NUM_REQ requesters
//
// Ports:
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   req_valid_i   : per-requester request valid
//   req_a_i       : packed operand a, requester k at [k*BITS_WIDTH +: BITS_WIDTH]
//   req_b_i       : packed operand b, same packing
//   req_cin_i     : per-requester carry-in
//   req_ready_o   : one-hot accept, only ever asserted in IDLE
//   rsp_valid_o   : result available (state RESP)
//   rsp_id_o      : index of the requester owning the result
//   rsp_sum_o     : a + b + cin, carry-out in the MSB
//   rsp_ready_i   : consumer accepts the response
//   busy_o        : high whenever the FSM is not IDLE
module adder_arbiter #(
    parameter  int BITS_WIDTH = pkg_bits::BITS_WIDTH,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*BITS_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*BITS_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]            req_cin_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [BITS_WIDTH:0]           rsp_sum_o,
    input  logic                          rsp_ready_i,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       cand;
    logic [ID_W-1:0]       sel_idx;
    logic                  sel_found;
    logic                  accept;

    logic [BITS_WIDTH-1:0] a_q;
    logic [BITS_WIDTH-1:0] b_q;
    logic                  cin_q;
    logic [ID_W-1:0]       id_q;
    logic [BITS_WIDTH:0]   sum_q;

    // Scan upward from ptr+1 so the most recently served requester has the
    // lowest priority on the next round.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign accept = (state == IDLE) && sel_found;

    // Gated by rst_n so no grant is advertised while reset is held.
    assign req_ready_o = (rst_n && accept) ? (NUM_REQ'(1) << sel_idx) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= ID_W'(NUM_REQ - 1);
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            id_q  <= '0;
            sum_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= req_a_i[sel_idx*BITS_WIDTH +: BITS_WIDTH];
                b_q   <= req_b_i[sel_idx*BITS_WIDTH +: BITS_WIDTH];
                cin_q <= req_cin_i[sel_idx];
                id_q  <= sel_idx;
            end
            if (state == EXEC) begin
                sum_q <= (BITS_WIDTH+1)'(a_q) + (BITS_WIDTH+1)'(b_q) + (BITS_WIDTH+1)'(cin_q);
            end
            // Pointer only moves on a completed response, so a request lost to
            // reset does not consume its turn.
            if (state == RESP && rsp_ready_i) begin
                ptr <= id_q;
            end
        end
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard testbench for adder_arbiter
module tb_adder_arbiter;

    localparam int W = 4;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [4:0] sum;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][W-1:0] a_arr = '0;
    logic [N-1:0][W-1:0] b_arr = '0;
    logic [N-1:0]        cin_arr = '0;
    logic [N*W-1:0]      req_a;
    logic [N*W-1:0]      req_b;
    logic [N-1:0]        req_ready;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [4:0]          rsp_sum;
    logic                rsp_ready = 1'b1;
    logic                busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    rsp_t exp_q[$];
    int   hs_cyc[$];
    rsp_t mon_e;

    assign req_a = a_arr;
    assign req_b = b_arr;

    adder_arbiter #(.BITS_WIDTH(W), .NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_cin_i   (cin_arr),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_ready_i (rsp_ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [4:0] sum);
        rsp_t e;
        e.id  = id;
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic single(input int k, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [4:0] sum);
        int t = 0;
        @(posedge clk); #1;
        a_arr[k]   = a;
        b_arr[k]   = b;
        cin_arr[k] = c;
        req_valid  = 4'b0001 << k;
        push(2'(k), sum);
        @(negedge clk);
        while (!req_ready[k] && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("single_grant", 32'(req_ready), 32'(4'b0001 << k));
        @(posedge clk); #1;
        req_valid = '0;
        drain();
    endtask

    // Monitor: every response handshake is compared against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id=%0d sum=%0h, required no response", rsp_id, rsp_sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] oh;

        // Reset state, with a requester already valid
        req_valid = 4'b0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Single request from requester 2, latency and busy profile
        @(posedge clk); #1;
        rst_n      = 1'b1;
        a_arr[2]   = 4'h7;
        b_arr[2]   = 4'h8;
        cin_arr[2] = 1'b1;
        push(2'd2, 5'h10);
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h4);
        check("t1_busy_idle", 32'(busy), 32'h0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_busy_exec", 32'(busy), 32'h1);
        check("t1_valid_exec", 32'(rsp_valid), 32'h0);
        check("t1_ready_exec", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("t1_valid_resp", 32'(rsp_valid), 32'h1);
        check("t1_busy_resp", 32'(busy), 32'h1);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_valid_after", 32'(rsp_valid), 32'h0);
        drain();

        // Maximum sum, with and without carry-in
        single(0, 4'hF, 4'hF, 1'b1, 5'h1F);
        single(0, 4'hF, 4'hF, 1'b0, 5'h1E);

        // Round-robin with all requesters valid, from a fresh reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_arr[0] = 4'h1; b_arr[0] = 4'h2; cin_arr[0] = 1'b0;
        a_arr[1] = 4'h3; b_arr[1] = 4'h4; cin_arr[1] = 1'b1;
        a_arr[2] = 4'h9; b_arr[2] = 4'h9; cin_arr[2] = 1'b0;
        a_arr[3] = 4'hF; b_arr[3] = 4'h1; cin_arr[3] = 1'b1;
        push(2'd0, 5'h03); push(2'd1, 5'h08); push(2'd2, 5'h12);
        push(2'd3, 5'h11); push(2'd0, 5'h03); push(2'd1, 5'h08);
        hs_cyc.delete();
        req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            oh = 4'b0001 << (g % 4);
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(oh));
            @(posedge clk); #1;
            if (g == 5) req_valid = '0;
            @(negedge clk);
            check("rr_ready_exec", 32'(req_ready), 32'h0);
            @(negedge clk);
            check("rr_ready_resp", 32'(req_ready), 32'h0);
        end
        drain();
        check("rr_hs_count", 32'(hs_cyc.size()), 32'd6);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check("rr_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
        end

        // Response backpressure with requesters 1 and 3 valid
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        push(2'd3, 5'h11);
        push(2'd1, 5'h08);
        @(negedge clk);
        check("bp_grant_first", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(rsp_valid), 32'h1);
            check("bp_id_hold", 32'(rsp_id), 32'h3);
            check("bp_sum_hold", 32'(rsp_sum), 32'h11);
            check("bp_ready_zero", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_grant_next", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Operand isolation: operands change after the accept edge
        @(posedge clk); #1;
        a_arr[2] = 4'h5; b_arr[2] = 4'h6; cin_arr[2] = 1'b0;
        req_valid = 4'b0100;
        push(2'd2, 5'h0B);
        @(negedge clk);
        check("iso_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        a_arr[2]  = 4'hF;
        @(posedge clk); #1;
        a_arr[2]  = 4'hA;
        drain();

        // Asynchronous reset while a response is pending
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        check("ar_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("ar_valid_before", 32'(rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_async", 32'(rsp_valid), 32'h0);
        check("ar_busy_async", 32'(busy), 32'h0);
        req_valid = 4'b1111;
        #1;
        check("ar_ready_in_reset", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        push(2'd0, 5'h03);
        @(negedge clk);
        check("ar_grant_after", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
